// File: rtl/ysyx_22041211_ifu.sv
// Instruction fetch unit: owns the PC, issues one imem fetch at a time and
// hands {inst, pc} to the decoder over a valid/ready handshake.
module ysyx_22041211_ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid_o,
  input  logic        imem_req_ready_i,
  output logic [31:0] imem_addr_o,
  input  logic        imem_resp_valid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        inst_valid_o,
  input  logic        inst_ready_i,
  output logic [31:0] inst_o,
  output logic [31:0] pc_o,
  input  logic        jmp_flag_i,
  input  logic [31:0] jmp_target_i,
  input  logic        branch_taken_i,
  input  logic [31:0] branch_target_i,
  input  logic        flush_i,
  input  logic [31:0] flush_pc_i,
  output logic        misalign_o
);

  typedef enum logic [2:0] {S_REQ, S_WAIT, S_DROP, S_HOLD, S_ERR} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] w_pc_nxt;
  logic [31:0] r_inst;
  logic [31:0] r_pc_out;
  logic        r_inst_valid;
  logic        w_inst_valid_nxt;
  logic        r_misalign;
  logic        w_misalign_nxt;
  logic        w_capture;
  logic        w_fire;
  logic [31:0] w_redirect_pc;

  assign w_fire        = r_inst_valid & inst_ready_i;
  assign w_redirect_pc = jmp_flag_i     ? jmp_target_i    :
                         branch_taken_i ? branch_target_i : r_pc + 32'd4;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_REQ;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_pc_nxt         = r_pc;
    w_inst_valid_nxt = r_inst_valid;
    w_misalign_nxt   = r_misalign;
    w_capture        = 1'b0;
    if ((r_state != S_ERR) && flush_i) begin
      w_pc_nxt         = flush_pc_i;
      w_inst_valid_nxt = 1'b0;
      case (r_state)
        S_WAIT:  w_state_nxt = imem_resp_valid_i ? S_REQ : S_DROP;
        S_DROP:  w_state_nxt = S_DROP;
        default: w_state_nxt = S_REQ;
      endcase
    end else begin
      case (r_state)
        S_REQ:  if (imem_req_ready_i) w_state_nxt = S_WAIT;
        S_WAIT: begin
          if (imem_resp_valid_i) begin
            w_capture        = 1'b1;
            w_inst_valid_nxt = 1'b1;
            w_state_nxt      = S_HOLD;
          end
        end
        S_HOLD: begin
          if (w_fire) begin
            w_inst_valid_nxt = 1'b0;
            w_pc_nxt         = w_redirect_pc;
            w_state_nxt      = S_REQ;
          end
        end
        S_DROP: if (imem_resp_valid_i) w_state_nxt = S_REQ;
        default: ;
      endcase
    end
    // A misaligned PC can only arrive via redirect or flush; it is terminal.
    if (w_pc_nxt[1:0] != 2'b00) begin
      w_state_nxt      = S_ERR;
      w_misalign_nxt   = 1'b1;
      w_inst_valid_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc         <= RESET_PC;
      r_inst       <= 32'd0;
      r_pc_out     <= RESET_PC;
      r_inst_valid <= 1'b0;
      r_misalign   <= 1'b0;
    end else begin
      r_pc         <= w_pc_nxt;
      r_inst_valid <= w_inst_valid_nxt;
      r_misalign   <= w_misalign_nxt;
      if (w_capture) begin
        r_inst   <= imem_rdata_i;
        r_pc_out <= r_pc;
      end
    end
  end

  // Flush withdraws a pending request so memory never accepts a stale fetch.
  assign imem_req_valid_o = (r_state == S_REQ) && !flush_i && !rst;
  assign imem_addr_o      = r_pc;
  assign inst_valid_o     = r_inst_valid;
  assign inst_o           = r_inst;
  assign pc_o             = r_pc_out;
  assign misalign_o       = r_misalign;

endmodule

// File: tb/tb_ysyx_22041211_ifu.sv
// Self-checking bench for ysyx_22041211_ifu: a PC reference model pushes the
// expected {inst, pc} when each fetch is issued and pops it at decoder handshake.
module tb_ysyx_22041211_ifu;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid_o;
  logic        imem_req_ready_i;
  logic [31:0] imem_addr_o;
  logic        imem_resp_valid_i;
  logic [31:0] imem_rdata_i;
  logic        inst_valid_o;
  logic        inst_ready_i;
  logic [31:0] inst_o;
  logic [31:0] pc_o;
  logic        jmp_flag_i;
  logic [31:0] jmp_target_i;
  logic        branch_taken_i;
  logic [31:0] branch_target_i;
  logic        flush_i;
  logic [31:0] flush_pc_i;
  logic        misalign_o;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] m_pc;
  logic [31:0] m_inst;
  logic        m_err;
  logic [63:0] q_exp[$];

  ysyx_22041211_ifu #(.RESET_PC(RST_PC)) dut (
    .clk              (clk),
    .rst              (rst),
    .imem_req_valid_o (imem_req_valid_o),
    .imem_req_ready_i (imem_req_ready_i),
    .imem_addr_o      (imem_addr_o),
    .imem_resp_valid_i(imem_resp_valid_i),
    .imem_rdata_i     (imem_rdata_i),
    .inst_valid_o     (inst_valid_o),
    .inst_ready_i     (inst_ready_i),
    .inst_o           (inst_o),
    .pc_o             (pc_o),
    .jmp_flag_i       (jmp_flag_i),
    .jmp_target_i     (jmp_target_i),
    .branch_taken_i   (branch_taken_i),
    .branch_target_i  (branch_target_i),
    .flush_i          (flush_i),
    .flush_pc_i       (flush_pc_i),
    .misalign_o       (misalign_o)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    imem_req_ready_i  = 1'b0;
    imem_resp_valid_i = 1'b0;
    imem_rdata_i      = 32'd0;
    inst_ready_i      = 1'b0;
    jmp_flag_i        = 1'b0;
    jmp_target_i      = 32'd0;
    branch_taken_i    = 1'b0;
    branch_target_i   = 32'd0;
    flush_i           = 1'b0;
    flush_pc_i        = 32'd0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    #1;
    check_eq("rst_req_valid", imem_req_valid_o, 0);
    check_eq("rst_addr", imem_addr_o, RST_PC);
    check_eq("rst_inst_valid", inst_valid_o, 0);
    check_eq("rst_inst", inst_o, 0);
    check_eq("rst_pc_o", pc_o, RST_PC);
    check_eq("rst_misalign", misalign_o, 0);
    repeat (2) tick();
    rst   = 1'b0;
    m_pc  = RST_PC;
    m_err = 1'b0;
    q_exp.delete();
  endtask

  // Wait for a request, check its address, accept it; optionally expect delivery.
  task automatic issue_req(input bit push);
    int n = 0;
    #1;
    while (!imem_req_valid_o && n < 20) begin
      tick();
      n++;
    end
    check_eq("req_timeout", {63'd0, imem_req_valid_o}, 1);
    check_eq("req_addr", imem_addr_o, m_pc);
    m_inst = m_pc ^ 32'h8000_0513;
    if (push) q_exp.push_back({m_inst, m_pc});
    imem_req_ready_i = 1'b1;
    tick();
    imem_req_ready_i = 1'b0;
  endtask

  task automatic give_resp(input int lat);
    for (int i = 1; i < lat; i++) begin
      check_eq("wait_req_valid", imem_req_valid_o, 0);
      tick();
    end
    imem_resp_valid_i = 1'b1;
    imem_rdata_i      = m_inst;
    #1;
    check_eq("valid_registered", inst_valid_o, 0);
    tick();
    imem_resp_valid_i = 1'b0;
    imem_rdata_i      = 32'd0;
  endtask

  task automatic accept(input int stall, input logic jf, input logic [31:0] jt,
                        input logic bt, input logic [31:0] btg,
                        input logic fl, input logic [31:0] flpc);
    logic [63:0] e;
    if (q_exp.size() == 0) begin
      check_eq("q_empty", 0, 1);
      e = 64'd0;
    end else begin
      e = q_exp.pop_front();
    end
    check_eq("hold_valid", inst_valid_o, 1);
    for (int i = 0; i < stall; i++) begin
      jmp_flag_i   = 1'b1;
      jmp_target_i = 32'hDEAD_BEE0;
      tick();
      check_eq("stall_inst", inst_o, e[63:32]);
      check_eq("stall_pc", pc_o, e[31:0]);
      check_eq("stall_no_req", imem_req_valid_o, 0);
      check_eq("stall_valid", inst_valid_o, 1);
    end
    inst_ready_i    = 1'b1;
    jmp_flag_i      = jf;
    jmp_target_i    = jt;
    branch_taken_i  = bt;
    branch_target_i = btg;
    flush_i         = fl;
    flush_pc_i      = flpc;
    #1;
    check_eq("fire_inst", inst_o, e[63:32]);
    check_eq("fire_pc", pc_o, e[31:0]);
    tick();
    clear_inputs();
    check_eq("post_fire_valid", inst_valid_o, 0);
    if (fl)      m_pc = flpc;
    else if (jf) m_pc = jt;
    else if (bt) m_pc = btg;
    else         m_pc = m_pc + 32'd4;
    if (m_pc[1:0] != 2'b00) m_err = 1'b1;
    check_eq("misalign", misalign_o, m_err);
  endtask

  task automatic fetch(input int lat, input int stall, input logic jf, input logic [31:0] jt,
                       input logic bt, input logic [31:0] btg,
                       input logic fl, input logic [31:0] flpc);
    issue_req(1'b1);
    give_resp(lat);
    accept(stall, jf, jt, bt, btg, fl, flpc);
  endtask

  initial begin
    do_reset();
    fetch(1, 0, 0, 0, 0, 0, 0, 0);
    // Jump has priority over a simultaneous taken branch.
    fetch(1, 0, 1, 32'h8000_0100, 1, 32'h8000_0300, 0, 0);
    fetch(3, 5, 0, 0, 0, 0, 0, 0);
    fetch(2, 0, 0, 0, 1, 32'h8000_0300, 0, 0);

    // Flush in WAIT, response two cycles later is dropped.
    issue_req(1'b0);
    flush_i    = 1'b1;
    flush_pc_i = 32'h8000_0200;
    tick();
    clear_inputs();
    check_eq("drop_valid", inst_valid_o, 0);
    check_eq("drop_no_req", imem_req_valid_o, 0);
    tick();
    imem_resp_valid_i = 1'b1;
    imem_rdata_i      = 32'hBAD0_0013;
    tick();
    clear_inputs();
    check_eq("drop_valid2", inst_valid_o, 0);
    m_pc = 32'h8000_0200;

    // Flush coincident with fire wins over the jump.
    fetch(1, 0, 1, 32'h8000_0500, 0, 0, 1, 32'h8000_0400);

    // Flush in WAIT alongside the response returns straight to REQ.
    issue_req(1'b0);
    flush_i           = 1'b1;
    flush_pc_i        = 32'h8000_0600;
    imem_resp_valid_i = 1'b1;
    imem_rdata_i      = 32'hBAD0_0013;
    tick();
    clear_inputs();
    #1;
    check_eq("flush_resp_req", imem_req_valid_o, 1);
    check_eq("flush_resp_valid", inst_valid_o, 0);
    m_pc = 32'h8000_0600;

    // Flush while in REQ withdraws the request.
    flush_i    = 1'b1;
    flush_pc_i = 32'hFFFF_FFFC;
    #1;
    check_eq("req_withdraw", imem_req_valid_o, 0);
    tick();
    clear_inputs();
    m_pc = 32'hFFFF_FFFC;

    fetch(1, 0, 0, 0, 0, 0, 0, 0);
    check_eq("wrap_model", m_pc, 0);
    fetch(1, 0, 0, 0, 1, 32'h8000_0102, 0, 0);
    for (int i = 0; i < 6; i++) begin
      imem_req_ready_i = 1'b1;
      tick();
      check_eq("err_no_req", imem_req_valid_o, 0);
      check_eq("err_valid", inst_valid_o, 0);
      check_eq("err_sticky", misalign_o, 1);
    end
    clear_inputs();

    // Reset mid-transaction (in HOLD) restores reset values.
    do_reset();
    issue_req(1'b1);
    give_resp(1);
    check_eq("pre_rst_valid", inst_valid_o, 1);
    do_reset();
    fetch(2, 1, 0, 0, 0, 0, 0, 0);
    issue_req(1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
